// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, access-size codes, stage states and lane-steering
// helpers for the memory-access pipeline stage.
package mem_pkg;

  localparam int ADDR_W      = 32;
  localparam int INSTR_W     = 32;
  localparam int WORD_W      = 32;
  localparam int DEST_SRC_W  = 2;
  localparam int REG_IDX_W   = 5;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_ST_W    = 2;

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

  localparam logic [DEST_SRC_W-1:0] DEST_SRC_NONE = 2'd0;

  typedef enum logic [MEM_ST_W-1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_REQ  = 2'd1,
    MEM_ST_DONE = 2'd2
  } mem_state_e;

  // Byte enables for an access of the given size at the given low address bits.
  function automatic logic [3:0] byte_en_f(input logic [MEM_COUNT_W-1:0] count,
                                           input logic [1:0] addr_lo);
    logic [3:0] be;
    case (count)
      MEM_COUNT_BYTE: be = 4'b0001 << addr_lo;
      MEM_COUNT_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      MEM_COUNT_WORD: be = 4'b1111;
      default:        be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data across every lane it could occupy.
  function automatic logic [WORD_W-1:0] wr_steer_f(input logic [MEM_COUNT_W-1:0] count,
                                                   input logic [WORD_W-1:0] data);
    logic [WORD_W-1:0] w;
    case (count)
      MEM_COUNT_BYTE: w = {4{data[7:0]}};
      MEM_COUNT_HALF: w = {2{data[15:0]}};
      default:        w = data;
    endcase
    return w;
  endfunction

  // True when the access does not sit on its natural alignment.
  function automatic logic misaligned_f(input logic [MEM_COUNT_W-1:0] count,
                                        input logic [1:0] addr_lo);
    logic m;
    case (count)
      MEM_COUNT_HALF: m = addr_lo[0];
      MEM_COUNT_WORD: m = (addr_lo != 2'b00);
      default:        m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_if.sv
// mem_if: valid/ready data-memory bus between the mem stage (master) and memory (slave).
interface mem_if;
  import mem_pkg::*;

  logic                valid;
  logic [ADDR_W-1:0]   addr;
  logic                wr_en;
  logic [WORD_W-1:0]   wr_data;
  logic [3:0]          byte_en;
  logic                ready;
  logic [WORD_W-1:0]   rd_data;

  modport master (output valid, addr, wr_en, wr_data, byte_en,
                  input  ready, rd_data);
  modport slave  (input  valid, addr, wr_en, wr_data, byte_en,
                  output ready, rd_data);
endinterface

// File: rtl/mem_load_ext.sv
// mem_load_ext: picks the addressed little-endian lane out of a read word and
// sign- or zero-extends it to a full word.
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [WORD_W-1:0]      rd_data_i,
  input  logic [1:0]             addr_lo_i,
  input  logic [MEM_COUNT_W-1:0] count_i,
  input  logic                   zero_ext_i,
  output logic [WORD_W-1:0]      data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension according to access size.
  always_comb begin
    byte_s = 8'd0;
    half_s = addr_lo_i[1] ? rd_data_i[31:16] : rd_data_i[15:0];
    case (addr_lo_i)
      2'd0:    byte_s = rd_data_i[7:0];
      2'd1:    byte_s = rd_data_i[15:8];
      2'd2:    byte_s = rd_data_i[23:16];
      2'd3:    byte_s = rd_data_i[31:24];
      default: byte_s = 8'd0;
    endcase
    case (count_i)
      MEM_COUNT_BYTE: data_o = zero_ext_i ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
      MEM_COUNT_HALF: data_o = zero_ext_i ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
      default:        data_o = rd_data_i;
    endcase
  end

endmodule

// File: rtl/mem.sv
// mem: memory-access pipeline stage. Registers execute results, runs one
// valid/ready bus transaction per load/store while stalling the pipeline,
// and presents aligned/extended load data to write-back.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (traps misaligned HALF/WORD).
module mem
  import mem_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   stall,
  input  logic [ADDR_W-1:0]      i_pc,
  input  logic [INSTR_W-1:0]     i_instr,
  input  logic [DEST_SRC_W-1:0]  i_dest_src,
  input  logic [REG_IDX_W-1:0]   i_dest_reg,
  input  logic [WORD_W-1:0]      i_alu_eval,
  input  logic [ADDR_W-1:0]      i_mem_req_addr,
  input  logic [WORD_W-1:0]      i_mem_req_wr_data,
  input  logic                   i_mem_req_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_mem_req_count,
  mem_if.master                  dmem,
  output logic                   o_stall_req,
  output logic [ADDR_W-1:0]      o_pc,
  output logic [INSTR_W-1:0]     o_instr,
  output logic [DEST_SRC_W-1:0]  o_dest_src,
  output logic [REG_IDX_W-1:0]   o_dest_reg,
  output logic [WORD_W-1:0]      o_alu_eval,
  output logic [WORD_W-1:0]      o_load_data,
  output logic                   o_bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  , output logic                 o_misaligned
`endif
);

  // The timeout counter is at least 8 bits, wider only for large limits.
  localparam int TO_W = (BUS_TIMEOUT > 255) ? $clog2(BUS_TIMEOUT + 1) : 8;

  mem_state_e             state_q;
  logic [ADDR_W-1:0]      pc_q;
  logic [INSTR_W-1:0]     instr_q;
  logic [DEST_SRC_W-1:0]  dest_src_q;
  logic [REG_IDX_W-1:0]   dest_reg_q;
  logic [WORD_W-1:0]      alu_q;
  logic [MEM_COUNT_W-1:0] count_q;
  logic [1:0]             addr_lo_q;
  logic                   is_store_q;
  logic [WORD_W-1:0]      load_data_q;
  logic                   bus_err_q;
  logic                   req_q;
  logic                   wr_en_q;
  logic [3:0]             byte_en_q;
  logic [ADDR_W-1:0]      dmem_addr_q;
  logic [WORD_W-1:0]      wr_data_q;
  logic [TO_W-1:0]        tmo_cnt_q;
  logic                   misaligned_q;

  logic                   capture_s;
  logic                   trap_s;
  logic                   go_s;
  logic                   timeout_hit_s;
  logic [WORD_W-1:0]      load_ext_d;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_s = misaligned_f(i_mem_req_count, i_mem_req_addr[1:0]);
`else
  assign trap_s = 1'b0;
`endif

  // Capture is suppressed while a transaction is outstanding, even if the
  // hazard unit failed to raise stall.
  assign capture_s     = !stall && (state_q != MEM_ST_REQ);
  assign go_s          = (i_mem_req_count != MEM_COUNT_NONE) && !trap_s;
  assign timeout_hit_s = (BUS_TIMEOUT != 0) && (tmo_cnt_q == TO_W'(BUS_TIMEOUT - 1));

  mem_load_ext u_load_ext (
    .rd_data_i  (dmem.rd_data),
    .addr_lo_i  (addr_lo_q),
    .count_i    (count_q),
    .zero_ext_i (instr_q[14]),
    .data_o     (load_ext_d)
  );

  // Stage FSM: input capture, bus request issue, completion/abort and result hold.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= MEM_ST_IDLE;
      pc_q         <= '0;
      instr_q      <= '0;
      dest_src_q   <= DEST_SRC_NONE;
      dest_reg_q   <= '0;
      alu_q        <= '0;
      count_q      <= MEM_COUNT_NONE;
      addr_lo_q    <= 2'd0;
      is_store_q   <= 1'b0;
      load_data_q  <= '0;
      bus_err_q    <= 1'b0;
      req_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      byte_en_q    <= 4'd0;
      dmem_addr_q  <= '0;
      wr_data_q    <= '0;
      tmo_cnt_q    <= '0;
      misaligned_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      if (capture_s) begin
        pc_q         <= i_pc;
        instr_q      <= i_instr;
        dest_src_q   <= trap_s ? DEST_SRC_NONE : i_dest_src;
        dest_reg_q   <= i_dest_reg;
        alu_q        <= i_alu_eval;
        count_q      <= i_mem_req_count;
        addr_lo_q    <= i_mem_req_addr[1:0];
        is_store_q   <= i_mem_req_wr_en;
        load_data_q  <= '0;
        tmo_cnt_q    <= '0;
        misaligned_q <= trap_s;
        dmem_addr_q  <= {i_mem_req_addr[ADDR_W-1:2], 2'b00};
        wr_data_q    <= wr_steer_f(i_mem_req_count, i_mem_req_wr_data);
        if (go_s) begin
          state_q   <= MEM_ST_REQ;
          req_q     <= 1'b1;
          wr_en_q   <= i_mem_req_wr_en;
          byte_en_q <= byte_en_f(i_mem_req_count, i_mem_req_addr[1:0]);
        end else begin
          state_q   <= MEM_ST_IDLE;
          req_q     <= 1'b0;
          wr_en_q   <= 1'b0;
          byte_en_q <= 4'd0;
        end
      end else if (state_q == MEM_ST_REQ) begin
        if (dmem.ready) begin
          // Ready wins over a timeout landing in the same cycle.
          state_q   <= MEM_ST_DONE;
          req_q     <= 1'b0;
          wr_en_q   <= 1'b0;
          byte_en_q <= 4'd0;
          if (!is_store_q) begin
            load_data_q <= load_ext_d;
          end
        end else if (timeout_hit_s) begin
          state_q     <= MEM_ST_DONE;
          req_q       <= 1'b0;
          wr_en_q     <= 1'b0;
          byte_en_q   <= 4'd0;
          bus_err_q   <= 1'b1;
          load_data_q <= '0;
          dest_src_q  <= DEST_SRC_NONE;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + TO_W'(1);
        end
      end
    end
  end

  assign dmem.valid   = req_q;
  assign dmem.addr    = dmem_addr_q;
  assign dmem.wr_en   = wr_en_q;
  assign dmem.wr_data = wr_data_q;
  assign dmem.byte_en = byte_en_q;

  assign o_stall_req  = req_q;
  assign o_pc         = pc_q;
  assign o_instr      = instr_q;
  assign o_dest_src   = dest_src_q;
  assign o_dest_reg   = dest_reg_q;
  assign o_alu_eval   = alu_q;
  assign o_load_data  = load_data_q;
  assign o_bus_err    = bus_err_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign o_misaligned = misaligned_q;
`endif

endmodule

// File: doc/mem.md
# mem

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of write-back. Registers execute-stage results, turns the execute stage's memory request (address, write data, write enable, byte count) into a valid/ready data-memory bus transaction with byte-lane steering, stalls the pipeline while the transaction is outstanding, and aligns/extends load data for write-back. Non-memory instructions pass through in one cycle.

## Interface
Parameters:
- BUS_TIMEOUT, 255: max REQ cycles without i_dmem_ready before abort; 0 disables timeout.

Ports:
- clk  in  1  clock; single clock domain.
- clr  in  1  reset, synchronous, active-high.
- stall  in  1  global hold; 1 freezes input register (hazard unit ORs o_stall_req into it).
- i_pc / i_instr  in  ADDR_W / INSTR_W  from execute.
- i_dest_src / i_dest_reg  in  DEST_SRC_W / REG_IDX_W  write-back selector and register index.
- i_alu_eval  in  WORD_W  ALU result.
- i_mem_req_addr  in  ADDR_W  byte address.
- i_mem_req_wr_data  in  WORD_W  store data, right-justified.
- i_mem_req_wr_en  in  1  1 = store, 0 = load.
- i_mem_req_count  in  MEM_COUNT_W  MEM_COUNT_NONE/BYTE/HALF/WORD.
- o_dmem_valid  out  1  bus request valid.
- o_dmem_addr  out  ADDR_W  word-aligned address (addr[1:0] = 0).
- o_dmem_wr_en  out  1  bus write.
- o_dmem_wr_data  out  WORD_W  lane-replicated store data.
- o_dmem_byte_en  out  4  byte enables.
- i_dmem_ready  in  1  bus accepts/completes request this cycle; i_dmem_rd_data valid same cycle for reads.
- i_dmem_rd_data  in  WORD_W  read word.
- o_stall_req  out  1  stage busy.
- o_pc / o_instr / o_dest_src / o_dest_reg / o_alu_eval  out  to write-back.
- o_load_data  out  WORD_W  aligned, extended load result.
- o_bus_err  out  1  one-cycle pulse on timeout.
- o_misaligned  out  1  only with MEM_MISALIGN_TRAP_EN.

## Operation
- Input register: on posedge with clr=0, stall=0, state != REQ, capture all i_* fields. Capture while in REQ is suppressed defensively.
- FSM states IDLE, REQ, DONE:
  - IDLE/DONE + capture with count != NONE (and not trapped) -> REQ; count == NONE -> IDLE.
  - REQ: o_dmem_valid=1, o_stall_req=1. i_dmem_ready=1 -> latch rd_data, -> DONE. Timeout hit -> o_bus_err pulse, load data 0, -> DONE.
  - DONE: o_stall_req=0; results held until next capture.
- Store steering: BYTE -> wr_data[7:0] x4, byte_en = 1<<addr[1:0]; HALF -> wr_data[15:0] x2, byte_en = addr[1] ? 1100 : 0011; WORD -> data as-is, 1111. Loads: byte_en per same rule, wr_en=0.
- Load extract, little-endian: BYTE lane addr[1:0]; HALF lane addr[1]; WORD whole. instr[14]=1 zero-extends, else sign-extends.
- Timeout counter: WORD-agnostic 8+ bit counter, cleared on REQ entry, abort when count == BUS_TIMEOUT-1 and no ready.
- Aborted or trapped access: o_dest_src forced to DEST_SRC_NONE.
- Bus outputs outside REQ: valid=0, wr_en=0, byte_en=0.

## Timing
- Reset (clr=1, next edge): state IDLE, all outputs 0, o_dest_src = DEST_SRC_NONE, timeout counter 0.
- Non-memory: 1 cycle in stage, no stall.
- Memory, ready in first REQ cycle: 1 stall cycle, result in DONE the following cycle. N wait cycles add N stall cycles.
- clr during REQ: valid drops at next edge; bus must tolerate abandoned requests.
- stall=1 in DONE: results held, no new capture.
- ready and timeout same cycle: ready wins, no error.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: HALF with addr[0]=1 or WORD with addr[1:0]!=0 never enters REQ; o_misaligned=1 while that instruction occupies the stage, dest_src forced NONE, no bus activity.
- Undefined: no o_misaligned port; offending low address bits ignored (HALF uses addr[1], WORD uses lane 0).

## Structure
- mem_codes.vh: MEM_COUNT_* (existing), new MEM_ST_IDLE/REQ/DONE and MEM_ST_W; config.vh widths reused.
- Sub-module mem_load_ext: combinational lane select + sign/zero extension.

## Test plan
- ALU op, count NONE, alu_eval 0x1234 -> o_alu_eval 0x1234 next cycle, o_stall_req never 1, valid never 1.
- SB addr 0x103, data 0xAB, ready same cycle -> byte_en 1000, wr_data 0xABABABAB, addr 0x100, one stall cycle.
- LB addr 0x102, rd 0x00800000, instr[14]=0 -> o_load_data 0xFFFFFF80; LBU -> 0x00000080.
- LW, ready held low 3 cycles -> o_stall_req high 4 cycles, data latched on ready cycle.
- BUS_TIMEOUT=4, ready never -> o_bus_err pulse after 4 REQ cycles, dest_src NONE, valid drops; clr mid-REQ -> valid 0 next edge, outputs reset.
- MEM_MISALIGN_TRAP_EN, LH addr 0x101 -> o_misaligned=1, no valid; without macro -> byte_en 0011, lane 0 data.
